ahb_slave_front: RTL and testbench

//  AHB-Lite slave front end of the AHB-to-APB bridge; sits directly behind the AHB bus pins.

---
 rtl/ahb_apb_pkg.sv | 20 ++
 rtl/ahb_slave_front_if.sv | 29 ++
 rtl/ahb_wbuf_fifo.sv | 41 ++++
 rtl/ahb_slave_front.sv | 80 ++++++++
 tb/tb_ahb_slave_front.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared types and constants for the AHB slave front end
package ahb_apb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WDATA, ST_RD_DRAIN, ST_RD_REQ, ST_RD_WAIT, ST_RD_DONE, ST_ERR1, ST_ERR2
  } front_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } wbuf_entry_t;
endpackage

// File: rtl/ahb_slave_front_if.sv
// ahb_slave_front_if: AHB-Lite pins plus the request/response channel to the APB controller
interface ahb_slave_front_if;
  import ahb_apb_pkg::*;
  logic              HSELAHB;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              wr_err;
  modport slave (
    input  HSELAHB, HADDR, HTRANS, HWRITE, HWDATA, req_ready, rsp_valid, rsp_err, rsp_rdata,
    output HRDATA, HREADY, HRESP, req_valid, req_write, req_addr, req_wdata, wr_err
  );
  modport master (
    output HSELAHB, HADDR, HTRANS, HWRITE, HWDATA, req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  HRDATA, HREADY, HRESP, req_valid, req_write, req_addr, req_wdata, wr_err
  );
endinterface

// File: rtl/ahb_wbuf_fifo.sv
// ahb_wbuf_fifo: posted-write buffer, synchronous FIFO with full/empty flags
module ahb_wbuf_fifo
  import ahb_apb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        HRESETn,
  input  logic        push_i,
  input  wbuf_entry_t din_i,
  input  logic        pop_i,
  output wbuf_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rp_q];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge HRESETn)
    if (!HRESETn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + PW'(do_push);
      rp_q  <= rp_q + PW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  // storage needs no reset; occupancy gates every read
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/ahb_slave_front.sv
// ahb_slave_front: AHB-Lite slave front end posting writes and serialising requests to APB
module ahb_slave_front
  import ahb_apb_pkg::*;
#(
  parameter int WBUF_DEPTH = 2
) (
  input logic               clk,
  input logic               HRESETn,
  ahb_slave_front_if.slave  bus
);
  front_state_e      state_q, state_d, accept_st;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              out_q, out_wr_q, wr_err_q;
  logic              hready, accept, rsp_ok, rd_req, drain_ok, push, full, empty;
  wbuf_entry_t       head;
  assign rsp_ok    = bus.rsp_valid & out_q;
  assign accept    = bus.HSELAHB & bus.HTRANS[1] & hready;
  assign accept_st = accept ? (bus.HWRITE ? ST_WDATA : ST_RD_DRAIN) : ST_IDLE;
  assign rd_req    = state_q == ST_RD_REQ;
  assign drain_ok  = ~out_q & ~empty & ~rd_req & (state_q != ST_RD_WAIT);
  assign push      = (state_q == ST_WDATA) & ~full;
  ahb_wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk     (clk),
    .HRESETn (HRESETn),
    .push_i  (push),
    .din_i   ({addr_q, bus.HWDATA}),
    .pop_i   (drain_ok & bus.req_ready),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // state register
  always_ff @(posedge clk or negedge HRESETn)
    if (!HRESETn) state_q <= ST_IDLE;
    else state_q <= state_d;
  // next state; states that end with HREADY=1 may pipeline a new transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RD_DONE, ST_ERR2: state_d = accept_st;
      ST_WDATA:    state_d = full ? ST_WDATA : accept_st;
      ST_RD_DRAIN: state_d = (empty & ~out_q) ? ST_RD_REQ : ST_RD_DRAIN;
      ST_RD_REQ:   state_d = bus.req_ready ? ST_RD_WAIT : ST_RD_REQ;
      ST_RD_WAIT:  state_d = rsp_ok ? (bus.rsp_err ? ST_ERR1 : ST_RD_DONE) : ST_RD_WAIT;
      ST_ERR1:     state_d = ST_ERR2;
      default:     state_d = ST_IDLE;
    endcase
  end
  // AHB response and request mux: a read in RD_REQ, otherwise the buffer head
  always_comb begin
    hready        = (state_q inside {ST_IDLE, ST_RD_DONE, ST_ERR2}) | push;
    bus.HREADY    = hready;
    bus.HRESP     = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    bus.HRDATA    = hrdata_q;
    bus.req_valid = rd_req | drain_ok;
    bus.req_write = ~rd_req;
    bus.req_addr  = rd_req ? addr_q : head.addr;
    bus.req_wdata = head.wdata;
    bus.wr_err    = wr_err_q;
  end
  // address phase capture, read data, outstanding tracking and sticky write error
  always_ff @(posedge clk or negedge HRESETn)
    if (!HRESETn) begin
      addr_q   <= '0;
      hrdata_q <= '0;
      out_q    <= 1'b0;
      out_wr_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (accept) addr_q <= bus.HADDR;
      if ((state_q == ST_RD_WAIT) & rsp_ok & ~bus.rsp_err) hrdata_q <= bus.rsp_rdata;
      if (bus.req_valid & bus.req_ready) begin
        out_q    <= 1'b1;
        out_wr_q <= bus.req_write;
      end else if (rsp_ok) out_q <= 1'b0;
      if (rsp_ok & out_wr_q & bus.rsp_err) wr_err_q <= 1'b1;
    end
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!HRESETn) bus.rsp_valid |-> out_q);
endmodule

// File: tb/tb_ahb_slave_front.sv
// tb_ahb_slave_front: directed checks of the AHB slave front end
module tb_ahb_slave_front;
  import ahb_apb_pkg::*;
  logic clk = 1'b0;
  logic HRESETn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  ahb_slave_front_if bus ();
  ahb_slave_front #(.WBUF_DEPTH(2)) dut (.clk(clk), .HRESETn(HRESETn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic addr(input logic sel, input logic wr, input logic [31:0] a);
    bus.HSELAHB = sel;
    bus.HTRANS  = sel ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.HWRITE  = wr;
    bus.HADDR   = a;
  endtask
  task automatic drain_one(input logic [31:0] a, input logic [31:0] d, input logic err);
    chk("drain_valid", bus.req_valid, 1);
    chk("drain_write", bus.req_write, 1);
    chk("drain_addr", bus.req_addr, a);
    chk("drain_wdata", bus.req_wdata, d);
    bus.req_ready = 1'b1;
    tick;
    bus.req_ready = 1'b0;
    chk("one_outstanding", bus.req_valid, 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_err   = err;
    tick;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
  endtask
  initial begin
    addr(0, 0, 0);
    bus.HWDATA = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err = 1'b0;
    bus.rsp_rdata = '0;
    tick;
    tick;
    chk("rst_hready", bus.HREADY, 1);
    chk("rst_hresp", bus.HRESP, 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    HRESETn = 1'b1;
    tick;
    // single posted write, controller always ready
    addr(1, 1, 32'h40);
    chk("t1_hready_a", bus.HREADY, 1);
    tick;
    addr(0, 0, 0);
    bus.HWDATA = 32'hDEAD_BEEF;
    chk("t1_hready_d", bus.HREADY, 1);
    tick;
    chk("t1_hready_idle", bus.HREADY, 1);
    drain_one(32'h40, 32'hDEAD_BEEF, 0);
    chk("t1_hready_end", bus.HREADY, 1);
    // three back-to-back writes with the controller stalled
    addr(1, 1, 32'h100);
    tick;
    addr(1, 1, 32'h104);
    bus.HWDATA = 32'h1111_0001;
    chk("t2_w1_hready", bus.HREADY, 1);
    tick;
    addr(1, 1, 32'h108);
    bus.HWDATA = 32'h1111_0002;
    chk("t2_w2_hready", bus.HREADY, 1);
    tick;
    addr(0, 0, 0);
    bus.HWDATA = 32'h1111_0003;
    chk("t2_w3_full", bus.HREADY, 0);
    chk("t2_head_valid", bus.req_valid, 1);
    chk("t2_head_addr", bus.req_addr, 32'h100);
    chk("t2_head_wdata", bus.req_wdata, 32'h1111_0001);
    tick;
    chk("t2_w3_still_full", bus.HREADY, 0);
    bus.req_ready = 1'b1;
    tick;
    bus.req_ready = 1'b0;
    chk("t2_w3_freed", bus.HREADY, 1);
    chk("t2_outstanding", bus.req_valid, 0);
    tick;
    bus.rsp_valid = 1'b1;
    tick;
    bus.rsp_valid = 1'b0;
    drain_one(32'h104, 32'h1111_0002, 0);
    drain_one(32'h108, 32'h1111_0003, 0);
    chk("t2_empty", bus.req_valid, 0);
    // write then read: read waits for the write response
    addr(1, 1, 32'h10);
    tick;
    addr(1, 0, 32'h14);
    bus.HWDATA = 32'hAAAA_5555;
    chk("t3_wr_hready", bus.HREADY, 1);
    tick;
    addr(0, 0, 0);
    chk("t3_rd_wait", bus.HREADY, 0);
    chk("t3_wr_first", bus.req_write, 1);
    chk("t3_wr_addr", bus.req_addr, 32'h10);
    bus.req_ready = 1'b1;
    tick;
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_no_rd_req", bus.req_valid, 0);
      chk("t3_rd_hold", bus.HREADY, 0);
      tick;
    end
    bus.rsp_valid = 1'b1;
    tick;
    bus.rsp_valid = 1'b0;
    chk("t3_drain_gap", bus.req_valid, 0);
    tick;
    chk("t3_rd_valid", bus.req_valid, 1);
    chk("t3_rd_write", bus.req_write, 0);
    chk("t3_rd_addr", bus.req_addr, 32'h14);
    bus.req_ready = 1'b1;
    tick;
    bus.req_ready = 1'b0;
    chk("t3_rd_wait2", bus.HREADY, 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'h1234;
    tick;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'hFFFF_FFFF;
    chk("t3_done_hready", bus.HREADY, 1);
    chk("t3_done_hresp", bus.HRESP, 0);
    chk("t3_hrdata", bus.HRDATA, 32'h1234);
    tick;
    // read with slave error, two-cycle ERROR response
    addr(1, 0, 32'h20);
    tick;
    addr(0, 0, 0);
    chk("t4_drain", bus.HREADY, 0);
    tick;
    chk("t4_req", bus.req_valid, 1);
    bus.req_ready = 1'b1;
    tick;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_err = 1'b1;
    tick;
    bus.rsp_valid = 1'b0;
    bus.rsp_err = 1'b0;
    chk("t4_err1_hresp", bus.HRESP, 1);
    chk("t4_err1_hready", bus.HREADY, 0);
    tick;
    chk("t4_err2_hresp", bus.HRESP, 1);
    chk("t4_err2_hready", bus.HREADY, 1);
    addr(1, 1, 32'h30);
    tick;
    addr(0, 0, 0);
    bus.HWDATA = 32'h5555;
    chk("t4_next_hresp", bus.HRESP, 0);
    chk("t4_next_hready", bus.HREADY, 1);
    tick;
    // posted write error is sticky
    chk("t5_wr_err_pre", bus.wr_err, 0);
    drain_one(32'h30, 32'h5555, 1);
    chk("t5_wr_err_set", bus.wr_err, 1);
    chk("t5_hresp_okay", bus.HRESP, 0);
    tick;
    tick;
    chk("t5_wr_err_hold", bus.wr_err, 1);
    // reset during RD_WAIT
    addr(1, 0, 32'h50);
    tick;
    addr(0, 0, 0);
    tick;
    bus.req_ready = 1'b1;
    tick;
    bus.req_ready = 1'b0;
    chk("t6_in_rd_wait", bus.HREADY, 0);
    HRESETn = 1'b0;
    #1;
    chk("t6a_hready", bus.HREADY, 1);
    chk("t6a_hresp", bus.HRESP, 0);
    chk("t6a_hrdata", bus.HRDATA, 0);
    chk("t6a_req_valid", bus.req_valid, 0);
    chk("t6a_wr_err", bus.wr_err, 0);
    tick;
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6a_quiet", bus.req_valid, 0);
      tick;
    end
    // reset with two buffered writes
    addr(1, 1, 32'h60);
    tick;
    addr(1, 1, 32'h64);
    bus.HWDATA = 32'h6000_0001;
    tick;
    addr(0, 0, 0);
    bus.HWDATA = 32'h6000_0002;
    chk("t6b_w2_hready", bus.HREADY, 1);
    tick;
    chk("t6b_buffered", bus.req_valid, 1);
    HRESETn = 1'b0;
    #1;
    chk("t6b_req_valid", bus.req_valid, 0);
    chk("t6b_hready", bus.HREADY, 1);
    tick;
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6b_quiet", bus.req_valid, 0);
      tick;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
